// File: rtl/debounced_logic_gate.sv
`default_nettype none
// ============================================================================
// Module   : debounced_logic_gate
// Purpose  : Synchronises and debounces WIDTH raw switch/button inputs, then
//            reduces the clean bits with a runtime-selected logic function.
//            The result is registered onto a single output (typically an LED),
//            and every transition of that output is counted.
//
// Ports    : clk        - system clock
//            rst        - synchronous reset, active-high; dominates all events
//            in_raw     - [WIDTH] asynchronous raw switch/button inputs
//            mode       - [3] function select, sampled every cycle
//                           0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,
//                           6 pass in_db[0], 7 constant 0
//            in_db      - [WIDTH] debounced input state
//            out        - registered result of the selected function
//            toggles    - [COUNT_W] out transitions since reset (wraps)
//            rise_pulse - [WIDTH] one-cycle pulse per 0->1 change of in_db
//                         (present only when the macro below is defined)
//
// Optional : DEBOUNCED_LOGIC_GATE_EDGE_PULSE_EN adds the rise_pulse output.
//
// Revision : 1.0 - initial release
// ============================================================================

module debounced_logic_gate #(
  parameter int WIDTH           = 2,  // number of input channels (>=1)
  parameter int DEBOUNCE_CYCLES = 4,  // stable cycles needed to accept a change (>=1)
  parameter int COUNT_W         = 8   // width of the transition counter
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_raw,
  input  logic [2:0]         mode,
  output logic [WIDTH-1:0]   in_db,
  output logic               out,
  output logic [COUNT_W-1:0] toggles
`ifdef DEBOUNCED_LOGIC_GATE_EDGE_PULSE_EN
  ,
  output logic [WIDTH-1:0]   rise_pulse
`endif
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; sizing for DEBOUNCE_CYCLES
  // keeps the width >=1 even when DEBOUNCE_CYCLES is 1.
  localparam int                  c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_term = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
  localparam logic [COUNT_W-1:0]  c_tog_one  = COUNT_W'(1);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser per channel
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: each channel counts consecutive cycles where the synchronised
  // input disagrees with the accepted state. Any agreement restarts the count,
  // so a glitch shorter than DEBOUNCE_CYCLES never reaches in_db.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   db_q;
  logic [WIDTH-1:0]   db_d;
  logic [c_cnt_w-1:0] cnt_q [WIDTH];
  logic [c_cnt_w-1:0] cnt_d [WIDTH];

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == c_cnt_term) begin
          // Terminal count: accept the new level, counter returns to 0.
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + c_cnt_one;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Selected logic function, evaluated on the registered debounced state so
  // that simultaneous channel updates are seen together one edge later.
  // --------------------------------------------------------------------------
  logic out_q;
  logic out_d;

  always_comb begin
    out_d = 1'b0;
    case (mode)
      3'd0:    out_d =  (&db_q);
      3'd1:    out_d =  (|db_q);
      3'd2:    out_d =  (^db_q);
      3'd3:    out_d = ~(&db_q);
      3'd4:    out_d = ~(|db_q);
      3'd5:    out_d = ~(^db_q);
      3'd6:    out_d =  db_q[0];
      default: out_d = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output register and transition counter (free-running wrap)
  // --------------------------------------------------------------------------
  logic [COUNT_W-1:0] tog_q;
  logic [COUNT_W-1:0] tog_d;

  always_comb begin
    tog_d = tog_q;
    if (out_d != out_q) begin
      tog_d = tog_q + c_tog_one;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 1'b0;
      tog_q <= '0;
    end else begin
      out_q <= out_d;
      tog_q <= tog_d;
    end
  end

`ifdef DEBOUNCED_LOGIC_GATE_EDGE_PULSE_EN
  // --------------------------------------------------------------------------
  // Rising-edge pulse: registered alongside in_db, so it is high during the
  // cycle right after the edge where in_db goes 0->1.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
    end else begin
      rise_q <= db_d & ~db_q;
    end
  end

  assign rise_pulse = rise_q;
`endif

  assign in_db   = db_q;
  assign out     = out_q;
  assign toggles = tog_q;

endmodule

`default_nettype wire

// File: tb/tb_debounced_logic_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounced_logic_gate
// Purpose  : Self-checking bench for debounced_logic_gate. A behavioural model
//            (sample history window + population-count function table) is
//            stepped once per clock edge and compared with the DUT every cycle,
//            alongside directed checks on latency, bounce rejection, reset
//            mid-count, truth tables and counter wrap.
// Revision : 1.0 - initial release
// ============================================================================

module tb_debounced_logic_gate;

  localparam int W  = 2;
  localparam int DC = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_raw;
  logic [2:0]    mode;
  logic [W-1:0]  in_db;
  logic          out;
  logic [CW-1:0] toggles;
`ifdef DEBOUNCED_LOGIC_GATE_EDGE_PULSE_EN
  logic [W-1:0]  rise_pulse;
`endif

  int n_vec;
  int n_err;

  debounced_logic_gate #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .COUNT_W         (CW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_raw     (in_raw),
    .mode       (mode),
    .in_db      (in_db),
    .out        (out),
    .toggles    (toggles)
`ifdef DEBOUNCED_LOGIC_GATE_EDGE_PULSE_EN
    ,
    .rise_pulse (rise_pulse)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  logic [W-1:0]  m_s1, m_s2, m_db, m_rise;
  logic          m_out;
  logic [CW-1:0] m_tog;
  logic [W-1:0]  hist [$];   // synchronised samples seen by the debouncer

  function automatic logic fref(input logic [2:0] md, input logic [W-1:0] v);
    int p;
    p = $countones(v);
    case (md)
      3'd0:    return (p == W);
      3'd1:    return (p > 0);
      3'd2:    return (p % 2 == 1);
      3'd3:    return (p != W);
      3'd4:    return (p == 0);
      3'd5:    return (p % 2 == 0);
      3'd6:    return v[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic [W-1:0] raw, input logic [2:0] md);
    logic [W-1:0] ndb;
    logic         nout;
    logic         all_diff;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_out = 1'b0; m_tog = '0; m_rise = '0;
      hist.delete();
    end else begin
      nout = fref(md, m_db);
      if (nout != m_out) m_tog = m_tog + CW'(1);
      hist.push_back(m_s2);
      if (hist.size() > DC) void'(hist.pop_front());
      ndb = m_db;
      // A channel flips once its last DC samples all disagreed with it.
      if (hist.size() == DC) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int k = 0; k < DC; k++) begin
            if (hist[k][b] == m_db[b]) all_diff = 1'b0;
          end
          if (all_diff) ndb[b] = ~m_db[b];
        end
      end
      m_rise = ndb & ~m_db;
      m_s2   = m_s1;
      m_s1   = raw;
      m_db   = ndb;
      m_out  = nout;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: advance model with pre-edge inputs, then compare.
  task automatic step();
    @(posedge clk);
    model_edge(rst, in_raw, mode);
    #1;
    chk("in_db", 32'(in_db), 32'(m_db));
    chk("out", 32'(out), 32'(m_out));
    chk("toggles", 32'(toggles), 32'(m_tog));
`ifdef DEBOUNCED_LOGIC_GATE_EDGE_PULSE_EN
    chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
`endif
  endtask

  logic [3:0] tt [8];

  initial begin
    int bitn;
    n_vec = 0;
    n_err = 0;
    m_s1 = '0; m_s2 = '0; m_db = '0; m_out = 1'b0; m_tog = '0; m_rise = '0;
    // Expected out per mode, bit index = in_raw pattern (00,01,10,11).
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b1010; tt[7] = 4'b0000;

    // ---- reset with inputs held high, then latency ----
    rst = 1'b1; in_raw = 2'b11; mode = 3'd0;
    repeat (3) step();
    chk("rst_in_db", 32'(in_db), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_toggles", 32'(toggles), 32'd0);
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k == 4) chk("lat_db_e4", 32'(in_db), 32'd0);
      if (k == 5) begin
        chk("lat_db_e5", 32'(in_db), 32'd3);
        chk("lat_out_e5", 32'(out), 32'd0);
      end
      if (k == 6) begin
        chk("lat_out_e6", 32'(out), 32'd1);
        chk("lat_tog_e6", 32'(toggles), 32'd1);
      end
    end

    // ---- truth table for every mode ----
    for (int m = 0; m < 8; m++) begin
      mode = 3'(m);
      for (int p = 0; p < 4; p++) begin
        in_raw = 2'(p);
        repeat (10) step();
        chk("truth_table", 32'(out), 32'(tt[m][p]));
      end
    end

    // ---- bounce on channel 0 ----
    mode = 3'd0; in_raw = 2'b00;
    repeat (10) step();
    in_raw = 2'b01; repeat (3) step();
    in_raw = 2'b00; step();
    in_raw = 2'b01;
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k < 5) chk("bounce_hold", 32'(in_db[0]), 32'd0);
      else       chk("bounce_rise", 32'(in_db[0]), 32'd1);
    end

    // ---- reset in the middle of a debounce count ----
    in_raw = 2'b00;
    repeat (10) step();
    in_raw = 2'b10;
    repeat (3) step();
    rst = 1'b1; step();
    chk("midrst_db", 32'(in_db), 32'd0);
    rst = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k < 5) chk("midrst_hold", 32'(in_db[1]), 32'd0);
      else       chk("midrst_rise", 32'(in_db[1]), 32'd1);
    end

    // ---- transition counter wrap: alternate AND/OR with in_db=01 ----
    rst = 1'b1; step(); rst = 1'b0;
    in_raw = 2'b01; mode = 3'd0;
    repeat (10) step();
    chk("wrap_start", 32'(toggles), 32'd0);
    for (int i = 0; i < 258; i++) begin
      mode = (i % 2 == 0) ? 3'd1 : 3'd0;
      step();
      if (i == 255) chk("wrap_256", 32'(toggles), 32'd0);
      if (i == 256) chk("wrap_257", 32'(toggles), 32'd1);
    end

`ifdef DEBOUNCED_LOGIC_GATE_EDGE_PULSE_EN
    // ---- rise pulse on 00->11, none on 11->00 ----
    in_raw = 2'b00; repeat (10) step();
    in_raw = 2'b11;
    for (int k = 0; k <= 7; k++) begin
      step();
      chk("rise_dir", 32'(rise_pulse), (k == 5) ? 32'd3 : 32'd0);
    end
    in_raw = 2'b00;
    for (int k = 0; k <= 7; k++) begin
      step();
      chk("fall_nopulse", 32'(rise_pulse), 32'd0);
    end
`endif

    // ---- randomized inputs, modes and occasional reset ----
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        bitn = int'($urandom_range(0, W - 1));
        in_raw[bitn] = ~in_raw[bitn];
      end
      if ($urandom_range(0, 7) == 0) mode = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debounced_logic_gate.md
Name: debounced_logic_gate

Overview:
- Parametrised successor to the two-input combinational gate demo on the TinyFPGA board.
- Takes WIDTH raw pushbutton/switch inputs, synchronises and debounces each one, then reduces the clean bits with a runtime-selectable logic function.
- Drives one registered output (LED) and counts output transitions.
- Sits between board pins and LED/logic in the top level.

Parameters:
- WIDTH, 2, number of input channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive clk cycles a synchronised input must differ from its debounced state before the state updates (>=1).
- COUNT_W, 8, width of the output-transition counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- in_raw  input  WIDTH  asynchronous raw switch/button inputs.
- mode  input  3  logic function select, sampled every cycle.
- in_db  output  WIDTH  debounced input state.
- out  output  1  registered result of the selected function.
- toggles  output  COUNT_W  number of out transitions since reset.

Behaviour:
- Reset: while rst=1 at a clk edge, all of the following clear to 0 and hold:
  - both synchroniser stages;
  - in_db;
  - every debounce counter;
  - out;
  - toggles.
  - rst dominates every other event in the same cycle.
- Synchroniser: two flops per channel. Output s[i] is in_raw[i] delayed by 2 edges.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - s[i]==in_db[i]: counter <= 0.
  - s[i]!=in_db[i] and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s[i]!=in_db[i] and counter == DEBOUNCE_CYCLES-1: in_db[i] <= s[i], counter <= 0.
  - Any glitch that returns s[i] to in_db[i] before the terminal count restarts the count from 0.
- Latency:
  - in_raw[i] changes before edge 0 and then holds stable.
  - in_db[i] updates at edge DEBOUNCE_CYCLES+1.
  - out reflects it at edge DEBOUNCE_CYCLES+2.
- Function, f(in_db) by mode:
  - 0 AND-reduce.
  - 1 OR-reduce.
  - 2 XOR-reduce.
  - 3 NAND.
  - 4 NOR.
  - 5 XNOR.
  - 6 pass in_db[0].
  - 7 constant 0.
- out <= f(in_db) every non-reset edge.
  - A mode change is visible on out one edge later; no debounce is applied to mode.
  - WIDTH=1: the reductions degenerate to the bit itself or its inverse.
- First edge after reset release: out <= f(0...0). For modes 3/4/5 this is 1 and counts as a transition.
- toggles:
  - Increments by 1 on any edge where the new out differs from the old out.
  - Wraps from 2^COUNT_W-1 to 0 with no saturation and no flag.
- Reset mid-debounce: the partial count is discarded. After release, an input still held high needs the full DEBOUNCE_CYCLES+1 edges to reach in_db.
- Channels are fully independent. Simultaneous updates on several channels in one edge are legal; out is evaluated once on the combined new in_db.

Optional Feature:
- Macro: DEBOUNCED_LOGIC_GATE_EDGE_PULSE_EN.
- Defined: adds output port rise_pulse, WIDTH bits.
  - rise_pulse[i]=1 for exactly the one cycle after the edge where in_db[i] goes 0->1; 0 otherwise.
  - Registered, cleared by rst.
  - A 1->0 change produces no pulse.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan (WIDTH=2, DEBOUNCE_CYCLES=4, COUNT_W=8 unless noted):
- Reset, in_raw=2'b11 held, mode=0:
  - -> all outputs 0 during rst.
  - After release, in_db=2'b11 at edge 5 and out=1 at edge 6.
  - toggles=1.
- Truth table, mode=0..6: step in_raw 00,01,10,11, each held 10 cycles.
  - -> out per table, e.g. mode=2 gives 0,1,1,0.
  - mode=7 always 0.
- Bounce: in_raw[0] pulses 1 for 3 cycles, then 0 for 1, then 1 held.
  - -> in_db[0] stays 0 during the bounce.
  - in_db[0] rises exactly 5 edges after the final 0->1.
- Reset mid-count: in_raw[1] rises, rst asserted after 3 cycles for 1 cycle, in_raw[1] held high.
  - -> in_db[1]=0 through the reset.
  - in_db[1] rises 5 edges after rst deasserts.
- Counter wrap (COUNT_W=2): toggle out 5 times via mode 0/1 with in_raw=01.
  - -> toggles sequence 1,2,3,0,1.
- With DEBOUNCED_LOGIC_GATE_EDGE_PULSE_EN: in_raw 00->11.
  - -> rise_pulse=2'b11 for exactly one cycle, coincident with the cycle after in_db changes.
  - in_raw 11->00 gives no pulse.
